// File: rtl/jtkiwi_gfx_romsrv.sv
// jtkiwi_gfx_romsrv
//   Serves GFX ROM fetches for two clients, the tilemap (scr) and object (obj)
//   engines, from a single SDRAM read port. Each client owns a one-entry cache
//   (tag/valid/data). A hit answers combinationally in the same cycle. Misses
//   are arbitrated onto a req/ack/rdy SDRAM bus, with one read in flight at a
//   time.
// Ports
//   clk, rst_n         system clock; synchronous active-low reset
//   flush              invalidates both cache entries
//   scr_addr/cs/ok/data  tilemap fetch handshake (data is registered)
//   obj_addr/cs/ok/data  object fetch handshake (data is registered)
//   sdr_addr/req       SDRAM read request, held until sdr_ack
//   sdr_ack/rdy/dout   SDRAM accept pulse and the read data pulse
// Parameters
//   AW word address width, DW data width, PRIO (1: scr always wins a tie)
module jtkiwi_gfx_romsrv #(
  parameter int AW   = 18,
  parameter int DW   = 32,
  parameter bit PRIO = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic [AW-1:0] scr_addr,
  input  logic          scr_cs,
  output logic          scr_ok,
  output logic [DW-1:0] scr_data,
  input  logic [AW-1:0] obj_addr,
  input  logic          obj_cs,
  output logic          obj_ok,
  output logic [DW-1:0] obj_data,
  output logic [AW-1:0] sdr_addr,
  output logic          sdr_req,
  input  logic          sdr_ack,
  input  logic          sdr_rdy,
  input  logic [DW-1:0] sdr_dout
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  // Client index 0 is scr, index 1 is obj.
  logic [AW-1:0] cl_addr [2];
  logic [1:0]    cl_cs;
  logic [1:0]    cl_ok;
  logic [1:0]    pend;

  logic [AW-1:0] tag_q  [2];
  logic [AW-1:0] tag_d  [2];
  logic [DW-1:0] data_q [2];
  logic [DW-1:0] data_d [2];
  logic [1:0]    valid_q, valid_d;
  logic [1:0]    state_q, state_d;
  logic          req_q, req_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          who_q, who_d;
  logic          last_q, last_d;
  logic          winner;

  assign cl_addr[0] = scr_addr;
  assign cl_addr[1] = obj_addr;
  assign cl_cs      = {obj_cs, scr_cs};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_hit
      assign cl_ok[gi] = cl_cs[gi] & valid_q[gi] & (tag_q[gi] == cl_addr[gi]);
      assign pend[gi]  = cl_cs[gi] & ~cl_ok[gi];
    end
  endgenerate

  // On a tie, round-robin picks whichever client was not granted last.
  assign winner = (pend[0] & pend[1]) ? (PRIO ? 1'b0 : ~last_q)
                                      : (pend[1] & ~pend[0]);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    who_d   = who_q;
    last_d  = last_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (|pend) begin
          who_d   = winner;
          last_d  = winner;
          addr_d  = cl_addr[winner];
          req_d   = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (sdr_ack) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The fill uses the latched request address, not the client's
        // current address, so a moved client simply misses again later.
        if (sdr_rdy) begin
          data_d[who_q]  = sdr_dout;
          tag_d[who_q]   = addr_q;
          valid_d[who_q] = 1'b1;
          state_d        = ST_IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    // Flush wins over a coincident fill: that entry is stored invalid.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
      who_q   <= 1'b0;
      last_q  <= 1'b1;  // obj, so scr wins the first tie
      valid_q <= '0;
      for (int i = 0; i < 2; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      who_q   <= who_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      for (int i = 0; i < 2; i++) begin
        tag_q[i]  <= tag_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign scr_ok   = cl_ok[0];
  assign obj_ok   = cl_ok[1];
  assign scr_data = data_q[0];
  assign obj_data = data_q[1];
  assign sdr_req  = req_q;
  assign sdr_addr = addr_q;

endmodule

// File: tb/tb_jtkiwi_gfx_romsrv.sv
// Testbench for jtkiwi_gfx_romsrv: directed scenarios followed by a randomized
// access sequence checked against a one-entry-per-client cache model and a
// behavioural SDRAM responder.
module tb_jtkiwi_gfx_romsrv;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [17:0] scr_addr, obj_addr;
  logic        scr_cs, obj_cs;
  logic        scr_ok, obj_ok;
  logic [31:0] scr_data, obj_data;
  logic [17:0] sdr_addr;
  logic        sdr_req, sdr_ack, sdr_rdy;
  logic [31:0] sdr_dout;

  logic        resp_en, resp_ack, resp_rdy;
  logic [31:0] resp_dout;
  logic        man_ack, man_rdy;
  logic [31:0] man_dout;
  int          ack_dly, rdy_dly;
  int          hold_viol;
  logic [17:0] req_log [$];

  int checks = 0;
  int errors = 0;

  assign sdr_ack  = resp_ack | man_ack;
  assign sdr_rdy  = resp_rdy | man_rdy;
  assign sdr_dout = man_rdy ? man_dout : resp_dout;

  jtkiwi_gfx_romsrv dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .scr_addr (scr_addr),
    .scr_cs   (scr_cs),
    .scr_ok   (scr_ok),
    .scr_data (scr_data),
    .obj_addr (obj_addr),
    .obj_cs   (obj_cs),
    .obj_ok   (obj_ok),
    .obj_data (obj_data),
    .sdr_addr (sdr_addr),
    .sdr_req  (sdr_req),
    .sdr_ack  (sdr_ack),
    .sdr_rdy  (sdr_rdy),
    .sdr_dout (sdr_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents seen through the SDRAM port.
  function automatic logic [31:0] mem(input logic [17:0] a);
    if (a == 18'h00100) return 32'hDEADBEEF;
    return {a[13:0], a} ^ 32'h5A5A1234;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SDRAM responder: accepts one request, acks after ack_dly cycles and
  // returns data rdy_dly cycles after the ack.
  initial begin
    logic [17:0] cur;
    resp_ack  = 1'b0;
    resp_rdy  = 1'b0;
    resp_dout = '0;
    hold_viol = 0;
    forever begin
      @(negedge clk);
      if (resp_en && sdr_req === 1'b1) begin
        cur = sdr_addr;
        req_log.push_back(cur);
        repeat (ack_dly) begin
          @(negedge clk);
          if (sdr_req !== 1'b1 || sdr_addr !== cur) hold_viol++;
        end
        resp_ack = 1'b1;
        @(negedge clk);
        resp_ack = 1'b0;
        if (sdr_req !== 1'b0) hold_viol++;
        repeat (rdy_dly) @(negedge clk);
        resp_rdy  = 1'b1;
        resp_dout = mem(cur);
        @(negedge clk);
        resp_rdy  = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ok(input bit c, output bit got);
    int n = 0;
    #1;
    got = c ? obj_ok : scr_ok;
    while (!got && n < 200) begin
      @(negedge clk);
      #1;
      n++;
      got = c ? obj_ok : scr_ok;
    end
  endtask

  task automatic wait_rdy_pos(output bit seen);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sdr_rdy !== 1'b1 && n < 100);
    seen = (sdr_rdy === 1'b1);
  endtask

  // One access by a single client; expected SDRAM traffic comes from the model.
  task automatic access(input bit c, input logic [17:0] a, input bit exp_miss, input string tag);
    int base;
    bit got;
    @(negedge clk);
    base = req_log.size();
    if (c) begin obj_addr = a; obj_cs = 1'b1; end
    else   begin scr_addr = a; scr_cs = 1'b1; end
    wait_ok(c, got);
    chk($sformatf("%s ok", tag), got, 1'b1);
    chk($sformatf("%s data", tag), c ? obj_data : scr_data, mem(a));
    chk($sformatf("%s sdr_reads", tag), req_log.size() - base, exp_miss ? 1 : 0);
    $display("txn %s client=%0d addr=%05h miss=%0d data=%08h", tag, c, a, exp_miss,
             c ? obj_data : scr_data);
    scr_cs = 1'b0;
    obj_cs = 1'b0;
  endtask

  initial begin
    bit          got;
    int          base;
    bit          m_valid [2];
    logic [17:0] m_tag [2];
    bit          c;
    logic [17:0] a;

    rst_n = 1'b0; flush = 1'b0;
    scr_addr = '0; obj_addr = '0; scr_cs = 1'b0; obj_cs = 1'b0;
    resp_en = 1'b1; man_ack = 1'b0; man_rdy = 1'b0; man_dout = '0;
    ack_dly = 0; rdy_dly = 3;

    // 1: reset state
    do_reset();
    @(negedge clk); #1;
    chk("rst sdr_req", sdr_req, 1'b0);
    chk("rst scr_ok", scr_ok, 1'b0);
    chk("rst obj_ok", obj_ok, 1'b0);
    chk("rst scr_data", scr_data, 32'h0);
    chk("rst obj_data", obj_data, 32'h0);

    // 2: basic miss then hit
    base = req_log.size();
    @(negedge clk);
    scr_addr = 18'h00100; scr_cs = 1'b1;
    @(negedge clk); #1;
    chk("t2 req", sdr_req, 1'b1);
    chk("t2 sdr_addr", sdr_addr, 18'h00100);
    chk("t2 ok before fill", scr_ok, 1'b0);
    wait_rdy_pos(got);
    chk("t2 rdy seen", got, 1'b1);
    @(negedge clk); #1;
    chk("t2 ok after rdy", scr_ok, 1'b1);
    chk("t2 data", scr_data, 32'hDEADBEEF);
    repeat (4) @(negedge clk);
    #1;
    chk("t2 no new req", req_log.size() - base, 1);
    chk("t2 req low", sdr_req, 1'b0);
    chk("t2 hit held", scr_ok, 1'b1);
    scr_cs = 1'b0; #1;
    chk("t2 cs low ok", scr_ok, 1'b0);
    $display("txn t2 scr addr=00100 data=%08h", scr_data);

    // 3: simultaneous misses, round-robin
    do_reset();
    base = req_log.size();
    @(negedge clk);
    scr_addr = 18'h00300; obj_addr = 18'h00400; scr_cs = 1'b1; obj_cs = 1'b1;
    wait_ok(0, got);
    wait_ok(1, got);
    #1;
    chk("t3 both ok", {scr_ok, obj_ok}, 2'b11);
    chk("t3 first grant", req_log[base], 18'h00300);
    chk("t3 second grant", req_log[base+1], 18'h00400);
    @(negedge clk);
    scr_addr = 18'h00320;
    wait_ok(0, got);
    chk("t3 scr-only grant", req_log[base+2], 18'h00320);
    @(negedge clk);
    scr_addr = 18'h00330; obj_addr = 18'h00410;
    wait_ok(0, got);
    wait_ok(1, got);
    #1;
    chk("t3 pair2 both ok", {scr_ok, obj_ok}, 2'b11);
    chk("t3 pair2 first", req_log[base+3], 18'h00410);
    chk("t3 pair2 second", req_log[base+4], 18'h00330);
    $display("txn t3 grants=%05h %05h %05h %05h %05h", req_log[base], req_log[base+1],
             req_log[base+2], req_log[base+3], req_log[base+4]);
    scr_cs = 1'b0; obj_cs = 1'b0;

    // 4: obj address moves while the fetch is in flight
    base = req_log.size();
    ack_dly = 0; rdy_dly = 6;
    @(negedge clk);
    obj_addr = 18'h02000; obj_cs = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk);
      got = (sdr_ack === 1'b1);
    end
    chk("t4 ack seen", got, 1'b1);
    @(negedge clk);
    obj_addr = 18'h02004;
    wait_rdy_pos(got);
    chk("t4 rdy seen", got, 1'b1);
    @(negedge clk); #1;
    chk("t4 ok after stale fill", obj_ok, 1'b0);
    chk("t4 first addr", req_log[base], 18'h02000);
    wait_ok(1, got);
    chk("t4 ok new addr", got, 1'b1);
    chk("t4 data", obj_data, mem(18'h02004));
    chk("t4 reads", req_log.size() - base, 2);
    chk("t4 second addr", req_log[base+1], 18'h02004);
    $display("txn t4 obj addr=02004 data=%08h", obj_data);
    obj_cs = 1'b0;

    // 5: flush coinciding with a scr fill
    base = req_log.size();
    rdy_dly = 2;
    @(negedge clk);
    scr_addr = 18'h00500; scr_cs = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk); #1;
      got = (sdr_rdy === 1'b1);
    end
    chk("t5 rdy seen", got, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; #1;
    chk("t5 ok after flush", scr_ok, 1'b0);
    wait_ok(0, got);
    chk("t5 refetch ok", got, 1'b1);
    chk("t5 refetch reads", req_log.size() - base, 2);
    chk("t5 refetch addr", req_log[base+1], 18'h00500);
    chk("t5 data", scr_data, mem(18'h00500));
    scr_cs = 1'b0;
    access(1'b1, 18'h02004, 1'b1, "t5 obj after flush");

    // 6: reset while waiting for data; the late rdy must be ignored
    resp_en = 1'b0;
    @(negedge clk);
    scr_addr = 18'h00600; scr_cs = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk); #1;
      got = (sdr_req === 1'b1);
    end
    chk("t6 req", got, 1'b1);
    man_ack = 1'b1;
    @(negedge clk);
    man_ack = 1'b0; scr_cs = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    man_rdy = 1'b1; man_dout = 32'h12345678;
    @(negedge clk);
    man_rdy = 1'b0; #1;
    chk("t6 req idle", sdr_req, 1'b0);
    chk("t6 data ignored", scr_data, 32'h0);
    scr_cs = 1'b1; #1;
    chk("t6 no ok", scr_ok, 1'b0);
    resp_en = 1'b1;
    @(negedge clk); #1;
    chk("t6 new grant from idle", sdr_req, 1'b1);
    wait_ok(0, got);
    chk("t6 refetch ok", got, 1'b1);
    chk("t6 refetch data", scr_data, mem(18'h00600));
    $display("txn t6 scr addr=00600 data=%08h", scr_data);
    scr_cs = 1'b0;

    // Randomized accesses against the cache model
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    m_valid[0] = 1'b0; m_valid[1] = 1'b0;
    m_tag[0] = '0; m_tag[1] = '0;
    for (int t = 0; t < 40; t++) begin
      ack_dly = $urandom_range(0, 3);
      rdy_dly = $urandom_range(0, 4);
      c = 1'($urandom_range(0, 1));
      a = 18'h00010 + 18'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        m_valid[0] = 1'b0; m_valid[1] = 1'b0;
      end
      access(c, a, !(m_valid[c] && m_tag[c] == a), $sformatf("rnd%0d", t));
      m_valid[c] = 1'b1;
      m_tag[c]   = a;
    end
    chk("sdr protocol", hold_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
